// File: rtl/alu_rsv_station_pkg.sv
// Shared types for the ALU reservation station: ALU op codes, flag bundle,
// operand slot and entry layouts.
package alu_rsv_station_pkg;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 5;

  typedef enum logic [3:0] {
    FU_OP_PASS_A = 4'd0,
    FU_OP_PASS_B = 4'd1,
    FU_OP_PLUS   = 4'd2,
    FU_OP_MINUS  = 4'd3,
    FU_OP_AND    = 4'd4,
    FU_OP_ORR    = 4'd5,
    FU_OP_EOR    = 4'd6,
    FU_OP_CSEL   = 4'd7
  } fu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic                    ready;
    logic [ROB_IDX_SIZE-1:0] tag;
    logic [GPR_SIZE-1:0]     value;
  } rs_operand_t;

  // Tags live inside the slots; the entry view only carries what select/issue needs.
  typedef struct packed {
    logic                    valid;
    fu_op_t                  fu_op;
    logic [ROB_IDX_SIZE-1:0] dst;
    logic                    set_nzcv;
    logic                    a_ready;
    logic [GPR_SIZE-1:0]     a_val;
    logic                    b_ready;
    logic [GPR_SIZE-1:0]     b_val;
    logic                    nzcv_ready;
    nzcv_t                   nzcv_val;
  } rs_entry_t;

endpackage

// File: rtl/alu_rsv_station_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the reservation station.
interface alu_rsv_station_if;
  import alu_rsv_station_pkg::*;

  logic                    in_flush;
  logic                    in_disp_valid;
  fu_op_t                  in_disp_fu_op;
  logic [ROB_IDX_SIZE-1:0] in_disp_dst_rob_index;
  logic                    in_disp_a_ready;
  logic                    in_disp_b_ready;
  logic                    in_disp_nzcv_ready;
  logic [ROB_IDX_SIZE-1:0] in_disp_a_tag;
  logic [ROB_IDX_SIZE-1:0] in_disp_b_tag;
  logic [ROB_IDX_SIZE-1:0] in_disp_nzcv_tag;
  logic [GPR_SIZE-1:0]     in_disp_a_val;
  logic [GPR_SIZE-1:0]     in_disp_b_val;
  nzcv_t                   in_disp_nzcv;
  logic                    in_disp_set_nzcv;
  logic                    out_disp_ready;
  logic                    in_cdb_valid;
  logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index;
  logic [GPR_SIZE-1:0]     in_cdb_value;
  nzcv_t                   in_cdb_nzcv;
  logic                    in_cdb_set_nzcv;
  logic                    in_fu_ready;
  logic                    out_fu_start;
  fu_op_t                  out_fu_op;
  logic [GPR_SIZE-1:0]     out_fu_val_a;
  logic [GPR_SIZE-1:0]     out_fu_val_b;
  logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index;
  logic                    out_fu_set_nzcv;
  nzcv_t                   out_fu_nzcv;

  modport master (
    output in_flush, in_disp_valid, in_disp_fu_op, in_disp_dst_rob_index,
           in_disp_a_ready, in_disp_b_ready, in_disp_nzcv_ready,
           in_disp_a_tag, in_disp_b_tag, in_disp_nzcv_tag,
           in_disp_a_val, in_disp_b_val, in_disp_nzcv, in_disp_set_nzcv,
           in_cdb_valid, in_cdb_rob_index, in_cdb_value, in_cdb_nzcv,
           in_cdb_set_nzcv, in_fu_ready,
    input  out_disp_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
           out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv
  );

  modport slave (
    input  in_flush, in_disp_valid, in_disp_fu_op, in_disp_dst_rob_index,
           in_disp_a_ready, in_disp_b_ready, in_disp_nzcv_ready,
           in_disp_a_tag, in_disp_b_tag, in_disp_nzcv_tag,
           in_disp_a_val, in_disp_b_val, in_disp_nzcv, in_disp_set_nzcv,
           in_cdb_valid, in_cdb_rob_index, in_cdb_value, in_cdb_nzcv,
           in_cdb_set_nzcv, in_fu_ready,
    output out_disp_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
           out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv
  );

endinterface

// File: rtl/rs_operand_slot.sv
// One operand slot: holds ready/tag/value, captures a matching broadcast and
// bypasses a broadcast that coincides with the dispatch write.
module rs_operand_slot
  import alu_rsv_station_pkg::*;
#(
  parameter int W = GPR_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  logic                    disp_ready,
  input  logic [ROB_IDX_SIZE-1:0] disp_tag,
  input  logic [W-1:0]            disp_val,
  input  logic                    cdb_en,
  input  logic [ROB_IDX_SIZE-1:0] cdb_tag,
  input  logic [W-1:0]            cdb_val,
  output logic                    ready,
  output logic [W-1:0]            value
);

  logic                    ready_r;
  logic [ROB_IDX_SIZE-1:0] tag_r;
  logic [W-1:0]            value_r;
  logic                    bypass_s;
  logic                    wake_s;

  // Tag compares for the incoming operand and for the held operand.
  always_comb begin
    bypass_s = cdb_en && !disp_ready && (disp_tag == cdb_tag);
    wake_s   = cdb_en && !ready_r && (tag_r == cdb_tag);
  end

  // Slot state: dispatch write wins over wakeup of the previous occupant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      tag_r   <= {ROB_IDX_SIZE{1'b0}};
      value_r <= {W{1'b0}};
    end else if (wr) begin
      ready_r <= disp_ready | bypass_s;
      tag_r   <= disp_tag;
      value_r <= bypass_s ? cdb_val : disp_val;
    end else if (wake_s) begin
      ready_r <= 1'b1;
      value_r <= cdb_val;
    end
  end

  assign ready = ready_r;
  assign value = value_r;

endmodule

// File: rtl/alu_rsv_station.sv
// ALU reservation station: lowest-free dispatch, broadcast wakeup, and
// lowest-ready single issue per cycle with flush.
module alu_rsv_station
  import alu_rsv_station_pkg::*;
#(
  parameter int RS_DEPTH = 8
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  alu_rsv_station_if.slave   bus
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0]     valid_r;
  fu_op_t                  op_r       [RS_DEPTH];
  logic [ROB_IDX_SIZE-1:0] dst_r      [RS_DEPTH];
  logic [RS_DEPTH-1:0]     set_nzcv_r;
  logic [CNT_W-1:0]        count_r;

  logic                    start_r;
  fu_op_t                  fu_op_r;
  logic [GPR_SIZE-1:0]     val_a_r;
  logic [GPR_SIZE-1:0]     val_b_r;
  logic [ROB_IDX_SIZE-1:0] fu_dst_r;
  logic                    fu_set_nzcv_r;
  nzcv_t                   fu_nzcv_r;

  logic [RS_DEPTH-1:0]     a_ready_s, b_ready_s, n_ready_s;
  logic [GPR_SIZE-1:0]     a_val_s    [RS_DEPTH];
  logic [GPR_SIZE-1:0]     b_val_s    [RS_DEPTH];
  logic [3:0]              n_val_s    [RS_DEPTH];
  rs_entry_t               entry_s    [RS_DEPTH];
  logic [RS_DEPTH-1:0]     ready_vec_s;
  logic [RS_DEPTH-1:0]     wr_s;
  logic [RS_DEPTH-1:0]     issue_mask_s;
  logic [IDX_W:0]          free_sel_s;
  logic [IDX_W:0]          rdy_sel_s;
  logic                    disp_ready_s;
  logic                    disp_acc_s;
  logic                    cdb_en_s;
  logic                    cdb_nzcv_en_s;
  logic                    issue_s;
  rs_operand_t             disp_a_s;
  rs_operand_t             disp_b_s;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [IDX_W:0] lowest_set(input logic [RS_DEPTH-1:0] vec);
    logic [IDX_W:0] res;
    res = {(IDX_W+1){1'b0}};
    for (int k = RS_DEPTH - 1; k >= 0; k--) begin
      if (vec[k]) begin
        res = {1'b1, IDX_W'(k)};
      end
    end
    return res;
  endfunction

  // Handshake qualification and free/ready selection from start-of-cycle state.
  always_comb begin
    disp_ready_s  = (count_r != CNT_W'(RS_DEPTH));
    disp_acc_s    = bus.in_disp_valid & disp_ready_s & ~bus.in_flush;
    cdb_en_s      = bus.in_cdb_valid & ~bus.in_flush;
    cdb_nzcv_en_s = cdb_en_s & bus.in_cdb_set_nzcv;
    free_sel_s    = lowest_set(~valid_r);
    rdy_sel_s     = lowest_set(ready_vec_s);
    issue_s       = bus.in_fu_ready & rdy_sel_s[IDX_W] & ~bus.in_flush;
    disp_a_s      = '{ready: bus.in_disp_a_ready, tag: bus.in_disp_a_tag,
                      value: bus.in_disp_a_val};
    disp_b_s      = '{ready: bus.in_disp_b_ready, tag: bus.in_disp_b_tag,
                      value: bus.in_disp_b_val};
    for (int k = 0; k < RS_DEPTH; k++) begin
      wr_s[k]         = disp_acc_s && free_sel_s[IDX_W] &&
                        (free_sel_s[IDX_W-1:0] == IDX_W'(k));
      issue_mask_s[k] = issue_s && (rdy_sel_s[IDX_W-1:0] == IDX_W'(k));
    end
  end

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
    rs_operand_slot #(.W(GPR_SIZE)) u_slot_a (
      .clk(in_clk), .rst_n(in_rst_n), .wr(wr_s[i]),
      .disp_ready(disp_a_s.ready), .disp_tag(disp_a_s.tag), .disp_val(disp_a_s.value),
      .cdb_en(cdb_en_s), .cdb_tag(bus.in_cdb_rob_index), .cdb_val(bus.in_cdb_value),
      .ready(a_ready_s[i]), .value(a_val_s[i])
    );

    rs_operand_slot #(.W(GPR_SIZE)) u_slot_b (
      .clk(in_clk), .rst_n(in_rst_n), .wr(wr_s[i]),
      .disp_ready(disp_b_s.ready), .disp_tag(disp_b_s.tag), .disp_val(disp_b_s.value),
      .cdb_en(cdb_en_s), .cdb_tag(bus.in_cdb_rob_index), .cdb_val(bus.in_cdb_value),
      .ready(b_ready_s[i]), .value(b_val_s[i])
    );

    rs_operand_slot #(.W(4)) u_slot_nzcv (
      .clk(in_clk), .rst_n(in_rst_n), .wr(wr_s[i]),
      .disp_ready(bus.in_disp_nzcv_ready), .disp_tag(bus.in_disp_nzcv_tag),
      .disp_val(bus.in_disp_nzcv),
      .cdb_en(cdb_nzcv_en_s), .cdb_tag(bus.in_cdb_rob_index), .cdb_val(bus.in_cdb_nzcv),
      .ready(n_ready_s[i]), .value(n_val_s[i])
    );

    // Entry view assembled from control registers and slot outputs.
    always_comb begin
      entry_s[i].valid      = valid_r[i];
      entry_s[i].fu_op      = op_r[i];
      entry_s[i].dst        = dst_r[i];
      entry_s[i].set_nzcv   = set_nzcv_r[i];
      entry_s[i].a_ready    = a_ready_s[i];
      entry_s[i].a_val      = a_val_s[i];
      entry_s[i].b_ready    = b_ready_s[i];
      entry_s[i].b_val      = b_val_s[i];
      entry_s[i].nzcv_ready = n_ready_s[i];
      entry_s[i].nzcv_val   = nzcv_t'(n_val_s[i]);
    end

    assign ready_vec_s[i] = entry_s[i].valid & entry_s[i].a_ready &
                            entry_s[i].b_ready & entry_s[i].nzcv_ready;
  end

  // Occupancy, entry control fields and the registered issue port.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      valid_r       <= {RS_DEPTH{1'b0}};
      set_nzcv_r    <= {RS_DEPTH{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      start_r       <= 1'b0;
      fu_op_r       <= FU_OP_PASS_A;
      val_a_r       <= {GPR_SIZE{1'b0}};
      val_b_r       <= {GPR_SIZE{1'b0}};
      fu_dst_r      <= {ROB_IDX_SIZE{1'b0}};
      fu_set_nzcv_r <= 1'b0;
      fu_nzcv_r     <= 4'b0000;
      for (int k = 0; k < RS_DEPTH; k++) begin
        op_r[k]  <= FU_OP_PASS_A;
        dst_r[k] <= {ROB_IDX_SIZE{1'b0}};
      end
    end else if (bus.in_flush) begin
      valid_r <= {RS_DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      start_r <= 1'b0;
    end else begin
      valid_r <= (valid_r & ~issue_mask_s) | wr_s;
      case ({disp_acc_s, issue_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      for (int k = 0; k < RS_DEPTH; k++) begin
        if (wr_s[k]) begin
          op_r[k]       <= bus.in_disp_fu_op;
          dst_r[k]      <= bus.in_disp_dst_rob_index;
          set_nzcv_r[k] <= bus.in_disp_set_nzcv;
        end
      end
      start_r <= issue_s;
      if (issue_s) begin
        fu_op_r       <= entry_s[rdy_sel_s[IDX_W-1:0]].fu_op;
        val_a_r       <= entry_s[rdy_sel_s[IDX_W-1:0]].a_val;
        val_b_r       <= entry_s[rdy_sel_s[IDX_W-1:0]].b_val;
        fu_dst_r      <= entry_s[rdy_sel_s[IDX_W-1:0]].dst;
        fu_set_nzcv_r <= entry_s[rdy_sel_s[IDX_W-1:0]].set_nzcv;
        fu_nzcv_r     <= entry_s[rdy_sel_s[IDX_W-1:0]].nzcv_val;
      end
    end
  end

  assign bus.out_disp_ready       = disp_ready_s;
  assign bus.out_fu_start         = start_r;
  assign bus.out_fu_op            = fu_op_r;
  assign bus.out_fu_val_a         = val_a_r;
  assign bus.out_fu_val_b         = val_b_r;
  assign bus.out_fu_dst_rob_index = fu_dst_r;
  assign bus.out_fu_set_nzcv      = fu_set_nzcv_r;
  assign bus.out_fu_nzcv          = fu_nzcv_r;

endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed bench for alu_rsv_station: latency, wakeup, bypass, full, flush, async reset.
module tb_alu_rsv_station;
  import alu_rsv_station_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_rsv_station_if bus();

  alu_rsv_station #(.RS_DEPTH(8)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input fu_op_t op, input logic ar, input logic [4:0] at,
                      input logic [63:0] av, input logic br, input logic [4:0] bt,
                      input logic [63:0] bv, input logic [4:0] dst);
    bus.in_disp_valid         = 1'b1;
    bus.in_disp_fu_op         = op;
    bus.in_disp_a_ready       = ar;
    bus.in_disp_a_tag         = at;
    bus.in_disp_a_val         = av;
    bus.in_disp_b_ready       = br;
    bus.in_disp_b_tag         = bt;
    bus.in_disp_b_val         = bv;
    bus.in_disp_dst_rob_index = dst;
    bus.in_disp_nzcv_ready    = 1'b1;
    bus.in_disp_nzcv_tag      = 5'd0;
    bus.in_disp_nzcv          = 4'b0000;
    bus.in_disp_set_nzcv      = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [63:0] val);
    bus.in_cdb_valid     = 1'b1;
    bus.in_cdb_rob_index = tag;
    bus.in_cdb_value     = val;
  endtask

  task automatic idle();
    bus.in_disp_valid   = 1'b0;
    bus.in_cdb_valid    = 1'b0;
    bus.in_cdb_set_nzcv = 1'b0;
    bus.in_cdb_nzcv     = 4'b0000;
    bus.in_flush        = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    disp(FU_OP_PASS_A, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0);
    cdb(5'd0, 64'd0);
    idle();
    bus.in_fu_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_start", 64'(bus.out_fu_start), 64'd0);
    check("rst_op", 64'(bus.out_fu_op), 64'(FU_OP_PASS_A));
    check("rst_val_a", bus.out_fu_val_a, 64'd0);
    check("rst_val_b", bus.out_fu_val_b, 64'd0);
    check("rst_dst", 64'(bus.out_fu_dst_rob_index), 64'd0);
    check("rst_nzcv", 64'(bus.out_fu_nzcv), 64'd0);
    check("rst_set_nzcv", 64'(bus.out_fu_set_nzcv), 64'd0);
    check("rst_disp_ready", 64'(bus.out_disp_ready), 64'd1);
    check("rst_count", 64'(dut.count_r), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Ready op: issue one edge after dispatch.
    bus.in_fu_ready = 1'b1;
    disp(FU_OP_PLUS, 1'b1, 5'd0, 64'd5, 1'b1, 5'd0, 64'd7, 5'd3);
    tick();
    idle();
    check("t1_no_start_yet", 64'(bus.out_fu_start), 64'd0);
    check("t1_count_1", 64'(dut.count_r), 64'd1);
    tick();
    check("t1_start", 64'(bus.out_fu_start), 64'd1);
    check("t1_val_a", bus.out_fu_val_a, 64'd5);
    check("t1_val_b", bus.out_fu_val_b, 64'd7);
    check("t1_dst", 64'(bus.out_fu_dst_rob_index), 64'd3);
    check("t1_op", 64'(bus.out_fu_op), 64'(FU_OP_PLUS));
    check("t1_count_0", 64'(dut.count_r), 64'd0);
    tick();
    check("t1_start_drop", 64'(bus.out_fu_start), 64'd0);
    check("t1_hold_val_a", bus.out_fu_val_a, 64'd5);

    // Wakeup from the broadcast bus.
    disp(FU_OP_MINUS, 1'b1, 5'd0, 64'd10, 1'b0, 5'd2, 64'd0, 5'd4);
    tick();
    idle();
    tick();
    check("t2_wait", 64'(bus.out_fu_start), 64'd0);
    check("t2_count", 64'(dut.count_r), 64'd1);
    cdb(5'd2, 64'd4);
    tick();
    idle();
    check("t2_not_same_cycle", 64'(bus.out_fu_start), 64'd0);
    tick();
    check("t2_start", 64'(bus.out_fu_start), 64'd1);
    check("t2_val_a", bus.out_fu_val_a, 64'd10);
    check("t2_val_b", bus.out_fu_val_b, 64'd4);
    check("t2_op", 64'(bus.out_fu_op), 64'(FU_OP_MINUS));
    check("t2_dst", 64'(bus.out_fu_dst_rob_index), 64'd4);

    // Same-cycle dispatch/broadcast bypass, including the flags slot.
    disp(FU_OP_PLUS, 1'b1, 5'd0, 64'd1, 1'b0, 5'd6, 64'd0, 5'd5);
    bus.in_disp_nzcv_ready = 1'b0;
    bus.in_disp_nzcv_tag   = 5'd6;
    bus.in_disp_set_nzcv   = 1'b1;
    cdb(5'd6, 64'd9);
    bus.in_cdb_set_nzcv = 1'b1;
    bus.in_cdb_nzcv     = 4'b1010;
    tick();
    idle();
    check("t3_start_low", 64'(bus.out_fu_start), 64'd0);
    tick();
    check("t3_start", 64'(bus.out_fu_start), 64'd1);
    check("t3_val_b", bus.out_fu_val_b, 64'd9);
    check("t3_dst", 64'(bus.out_fu_dst_rob_index), 64'd5);
    check("t3_nzcv", 64'(bus.out_fu_nzcv), 64'hA);
    check("t3_set_nzcv", 64'(bus.out_fu_set_nzcv), 64'd1);

    // Fill, full behaviour, ordered drain and stall.
    bus.in_fu_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp(FU_OP_PLUS, 1'b1, 5'd0, 64'(100 + i), 1'b0, 5'd1, 64'd0, 5'(i));
      tick();
    end
    check("t4_full_ready", 64'(bus.out_disp_ready), 64'd0);
    check("t4_full_count", 64'(dut.count_r), 64'd8);
    disp(FU_OP_PLUS, 1'b1, 5'd0, 64'd0, 1'b1, 5'd0, 64'd0, 5'd15);
    tick();
    idle();
    check("t4_ninth_ignored", 64'(dut.count_r), 64'd8);
    cdb(5'd1, 64'h55);
    tick();
    idle();
    tick();
    check("t4_stall_before", 64'(bus.out_fu_start), 64'd0);
    bus.in_fu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.in_fu_ready = 1'b0;
        tick();
        check("t4_stall_mid", 64'(bus.out_fu_start), 64'd0);
        bus.in_fu_ready = 1'b1;
      end
      tick();
      check("t4_start", 64'(bus.out_fu_start), 64'd1);
      check("t4_order_dst", 64'(bus.out_fu_dst_rob_index), 64'(i));
      check("t4_val_a", bus.out_fu_val_a, 64'(100 + i));
      check("t4_val_b", bus.out_fu_val_b, 64'h55);
    end
    tick();
    check("t4_drained_start", 64'(bus.out_fu_start), 64'd0);
    check("t4_drained_count", 64'(dut.count_r), 64'd0);

    // Flush beats concurrent dispatch and broadcast.
    bus.in_fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(FU_OP_AND, 1'b1, 5'd0, 64'd1, 1'b0, 5'd7, 64'd0, 5'(8 + i));
      tick();
    end
    check("t5_four_waiting", 64'(dut.count_r), 64'd4);
    disp(FU_OP_PLUS, 1'b1, 5'd0, 64'd3, 1'b1, 5'd0, 64'd3, 5'd12);
    cdb(5'd7, 64'h77);
    bus.in_flush    = 1'b1;
    bus.in_fu_ready = 1'b1;
    tick();
    idle();
    check("t5_count", 64'(dut.count_r), 64'd0);
    check("t5_valid", 64'(dut.valid_r), 64'd0);
    check("t5_start", 64'(bus.out_fu_start), 64'd0);
    check("t5_disp_ready", 64'(bus.out_disp_ready), 64'd1);
    tick();
    tick();
    check("t5_no_ghost_issue", 64'(bus.out_fu_start), 64'd0);

    // Asynchronous reset while an issue is on the port.
    disp(FU_OP_PLUS, 1'b1, 5'd0, 64'h11, 1'b1, 5'd0, 64'h22, 5'd2);
    tick();
    disp(FU_OP_PLUS, 1'b1, 5'd0, 64'd0, 1'b0, 5'd9, 64'd0, 5'd6);
    tick();
    idle();
    check("t6_start", 64'(bus.out_fu_start), 64'd1);
    check("t6_val_a", bus.out_fu_val_a, 64'h11);
    check("t6_count", 64'(dut.count_r), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_start", 64'(bus.out_fu_start), 64'd0);
    check("t6_rst_count", 64'(dut.count_r), 64'd0);
    check("t6_rst_valid", 64'(dut.valid_r), 64'd0);
    check("t6_rst_val_a", bus.out_fu_val_a, 64'd0);
    check("t6_rst_op", 64'(bus.out_fu_op), 64'(FU_OP_PASS_A));
    check("t6_rst_disp_ready", 64'(bus.out_disp_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t6_after_rst_start", 64'(bus.out_fu_start), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rsv_station.md
# alu_rsv_station

Reservation station for the ALU path, directly upstream of the functional units. Holds dispatched ALU micro-ops until both operands and the NZCV input are available. Captures results from the single functional-unit result bus (wakeup), then issues one ready op per cycle to the ALU start interface. Flushes on branch mispredict.

## Interface
Parameters:
- `RS_DEPTH`, default 8: number of entries; power of two, at least 2.

Ports (widths use `GPR_SIZE` = 64 and `ROB_IDX_SIZE` from the shared header):
- `in_clk` in 1: clock. One clock domain; all state on rising edge.
- `in_rst_n` in 1: asynchronous, active-low reset.
- `in_flush` in 1: mispredict. Clears all entries at the next edge.
- `in_disp_valid` in 1: dispatch request.
- `in_disp_fu_op` in `fu_op_t`: operation.
- `in_disp_dst_rob_index` in `ROB_IDX_SIZE`: destination ROB slot.
- `in_disp_a_ready`, `in_disp_b_ready`, `in_disp_nzcv_ready` in 1 each: operand already valid.
- `in_disp_a_tag`, `in_disp_b_tag`, `in_disp_nzcv_tag` in `ROB_IDX_SIZE` each: producer ROB index when not ready.
- `in_disp_a_val`, `in_disp_b_val` in `GPR_SIZE`: operand values when ready.
- `in_disp_nzcv` in `nzcv_t`: flags value when ready.
- `in_disp_set_nzcv` in 1: op writes flags.
- `out_disp_ready` out 1: at least one free entry (combinational from occupancy).
- `in_cdb_valid` in 1: result broadcast valid (the FU `out_rob_done`).
- `in_cdb_rob_index` in `ROB_IDX_SIZE`, `in_cdb_value` in `GPR_SIZE`, `in_cdb_nzcv` in `nzcv_t`, `in_cdb_set_nzcv` in 1: broadcast payload.
- `in_fu_ready` in 1: ALU accepts an op this cycle (FU `out_rs_alu_ready`).
- `out_fu_start` out 1: registered issue strobe.
- `out_fu_op` out `fu_op_t`, `out_fu_val_a` out `GPR_SIZE`, `out_fu_val_b` out `GPR_SIZE`, `out_fu_dst_rob_index` out `ROB_IDX_SIZE`, `out_fu_set_nzcv` out 1, `out_fu_nzcv` out `nzcv_t`: registered issue payload.

## Operation
- Entry fields: valid, fu_op, dst, set_nzcv, three operand slots (ready, tag, value).
- Dispatch is accepted when `in_disp_valid & out_disp_ready`. The op is written into the lowest-index free entry.
- Wakeup applies to every valid entry:
  - A or B slot, not ready, tag == `in_cdb_rob_index`, `in_cdb_valid`: capture `in_cdb_value` and set ready.
  - NZCV slot matches under the same condition plus `in_cdb_set_nzcv`: capture `in_cdb_nzcv`.
- Same-cycle dispatch/broadcast bypass: a dispatching operand whose tag matches a valid broadcast is written already ready with the broadcast value.
- Issue select: the lowest-index entry with valid and all three slots ready, sampled at the start of the cycle. A same-cycle wakeup does not make an entry issuable until the next cycle.
- If `in_fu_ready` and a selection exists:
  - The payload is registered onto the `out_fu_*` outputs.
  - `out_fu_start` is set to 1.
  - The entry is freed.
- Otherwise `out_fu_start` goes to 0 and the payload outputs hold.
- An entry freed by issue in a cycle is not reusable by a dispatch in that same cycle. `out_disp_ready` reflects the start-of-cycle occupancy.
- Flush has priority over everything at the edge:
  - All valid bits are cleared.
  - `out_fu_start` goes to 0.
  - A concurrent dispatch is dropped.
  - A concurrent broadcast is ignored.
- Occupancy counter width is `$clog2(RS_DEPTH)+1`. Dispatch and issue in the same cycle leave the count unchanged.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - All valid bits are 0 and the count is 0.
  - `out_fu_start` is 0.
  - `out_fu_op` is `FU_OP_PASS_A`.
  - `out_fu_val_a`, `out_fu_val_b`, `out_fu_dst_rob_index`, `out_fu_nzcv` and `out_fu_set_nzcv` are 0.
  - `out_disp_ready` is 1.
- Latency: dispatch with all operands ready at edge k, then `out_fu_start` high in cycle k+1 (issue at edge k+1), provided `in_fu_ready` is high.
- Wakeup latency: broadcast at edge k makes the entry selectable in cycle k, so it can issue at edge k+1.
- Reset asserted mid-operation discards all entries immediately; outputs go to their reset values without waiting for a clock.
- Full (count == `RS_DEPTH`): `out_disp_ready` is 0. A dispatch offered while full is ignored.

## Structure
- The shared package gains:
  - `rs_entry_t`, a packed struct of the entry fields.
  - `rs_operand_t`, with fields ready, tag and value.
- A sub-module `rs_operand_slot` holds one operand slot with its tag compare, capture and bypass logic. It is instantiated three times per entry, with the NZCV slot using a 4-bit value.
- A priority encoder picks both the lowest free entry and the lowest ready entry. It is written as a function, not a separate module.

## Test plan
- Reset, then dispatch PLUS with a=5, b=7, both ready, dst=3, `in_fu_ready`=1. Expect `out_fu_start`=1 one cycle later with val_a=5, val_b=7, dst=3. Expect the count back to 0.
- Dispatch MINUS with a ready=10 and b tag=2 not ready. Expect no issue. Broadcast rob 2 with value=4. Expect issue on the following edge with val_b=4.
- Dispatch with b tag=6 in the same cycle as a broadcast of rob 6 with value=9. Expect the entry captured ready and issued next cycle with val_b=9.
- Fill 8 entries, all waiting on tag 1. Expect `out_disp_ready`=0 and a 9th dispatch ignored. Broadcast tag 1. Expect issues in index order 0..7 on consecutive edges while `in_fu_ready`=1. Toggling `in_fu_ready` low stalls issue.
- Four entries waiting, then `in_flush` together with a dispatch and a matching broadcast. Expect count=0, `out_fu_start`=0, and the dispatched op absent.
- Assert `in_rst_n` low between edges while `out_fu_start`=1. Expect `out_fu_start`=0 immediately and all entries gone.
